// File: rtl/jtag_tap_ctrl_if.sv
// Pin-level bundle between the TAP controller and its JTAG host / scan chains.
// The slave modport is the TAP controller; master is the host/chain side.
interface jtag_tap_ctrl_if #(
  parameter int IR_W = 4
);
  logic            tms;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic            bsr_so;
  logic            scan_so;
  logic            capture_dr;
  logic            shift_dr;
  logic            update_dr;
  logic            bsr_sel;
  logic            bsr_en;
  logic            scan_sel;
  logic [IR_W-1:0] ir_out;

  modport master (
    output tms, tdi, bsr_so, scan_so,
    input  tdo, tdo_en, capture_dr, shift_dr, update_dr,
           bsr_sel, bsr_en, scan_sel, ir_out
  );

  modport slave (
    input  tms, tdi, bsr_so, scan_so,
    output tdo, tdo_en, capture_dr, shift_dr, update_dr,
           bsr_sel, bsr_en, scan_sel, ir_out
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: TMS-decoded 16-state FSM, instruction register, DR strobes, TDO mux.
// Define JTAG_IDCODE_EN to build the 32-bit IDCODE register and make OP_IDCODE the reset instruction.
module jtag_tap_ctrl #(
  parameter int              IR_W       = 4,
`ifdef JTAG_IDCODE_EN
  parameter logic [31:0]     IDCODE_VAL = 32'h1234_5001,
  parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(2),
`endif
  parameter logic [IR_W-1:0] OP_EXTEST  = IR_W'(0),
  parameter logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1),
  parameter logic [IR_W-1:0] OP_SCAN    = IR_W'(3),
  parameter logic [IR_W-1:0] OP_BYPASS  = '1
) (
  input logic            clock,
  input logic            rst_l,
  jtag_tap_ctrl_if.slave jtag
);

  // Standard 1149.1 state encodings, so the state register reads like a datasheet.
  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] RESET_OP = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] RESET_OP = OP_BYPASS;
`endif
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

  tap_state_t      state;
  tap_state_t      next_state;
  logic [IR_W-1:0] ir;
  logic [IR_W-1:0] ir_sh;
  logic            byp;
  logic            bsr_sel;
  logic            scan_sel;
  logic            dr_strobe_en;
  logic            tdo;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) state <= TLR;
    else        state <= next_state;
  end

  // NOTE: next_state defaults to state first, so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      TLR:     next_state = jtag.tms ? TLR    : RTI;
      RTI:     next_state = jtag.tms ? SEL_DR : RTI;
      SEL_DR:  next_state = jtag.tms ? SEL_IR : CAP_DR;
      SEL_IR:  next_state = jtag.tms ? TLR    : CAP_IR;
      CAP_DR:  next_state = jtag.tms ? EX1_DR : SH_DR;
      SH_DR:   next_state = jtag.tms ? EX1_DR : SH_DR;
      EX1_DR:  next_state = jtag.tms ? UPD_DR : PA_DR;
      PA_DR:   next_state = jtag.tms ? EX2_DR : PA_DR;
      EX2_DR:  next_state = jtag.tms ? UPD_DR : SH_DR;
      UPD_DR:  next_state = jtag.tms ? SEL_DR : RTI;
      CAP_IR:  next_state = jtag.tms ? EX1_IR : SH_IR;
      SH_IR:   next_state = jtag.tms ? EX1_IR : SH_IR;
      EX1_IR:  next_state = jtag.tms ? UPD_IR : PA_IR;
      PA_IR:   next_state = jtag.tms ? EX2_IR : PA_IR;
      EX2_IR:  next_state = jtag.tms ? UPD_IR : SH_IR;
      UPD_IR:  next_state = jtag.tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // The active instruction only moves on update or on TLR entry, never while ir_sh is shifting.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      ir    <= RESET_OP;
      ir_sh <= '0;
    end else begin
      if (state == CAP_IR)     ir_sh <= IR_CAPTURE;
      else if (state == SH_IR) ir_sh <= {jtag.tdi, ir_sh[IR_W-1:1]};

      if (next_state == TLR)    ir <= RESET_OP;
      else if (state == UPD_IR) ir <= ir_sh;
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l)               byp <= 1'b0;
    else if (state == CAP_DR) byp <= 1'b0;
    else if (state == SH_DR)  byp <= jtag.tdi;
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_sh;
  logic        id_sel;

  assign id_sel = (ir == OP_IDCODE);

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l)               id_sh <= IDCODE_VAL;
    else if (state == CAP_DR) id_sh <= IDCODE_VAL;
    else if (state == SH_DR)  id_sh <= {jtag.tdi, id_sh[31:1]};
  end
`endif

  assign bsr_sel      = (ir == OP_EXTEST) || (ir == OP_SAMPLE);
  assign scan_sel     = (ir == OP_SCAN);
  // Chain strobes only fire when a real chain is selected; bypass/IDCODE scans leave cells untouched.
  assign dr_strobe_en = bsr_sel || scan_sel;

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = ir_sh[0];
    end else if (state == SH_DR) begin
      if (bsr_sel)       tdo = jtag.bsr_so;
      else if (scan_sel) tdo = jtag.scan_so;
`ifdef JTAG_IDCODE_EN
      else if (id_sel)   tdo = id_sh[0];
`endif
      else               tdo = byp;
    end
  end

  assign jtag.tdo        = tdo;
  assign jtag.tdo_en     = (state == SH_DR) || (state == SH_IR);
  assign jtag.capture_dr = (state == CAP_DR) && dr_strobe_en;
  assign jtag.shift_dr   = (state == SH_DR)  && dr_strobe_en;
  assign jtag.update_dr  = (state == UPD_DR) && dr_strobe_en;
  assign jtag.bsr_sel    = bsr_sel;
  assign jtag.bsr_en     = (ir == OP_EXTEST);
  assign jtag.scan_sel   = scan_sel;
  assign jtag.ir_out     = ir;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: FSM reachability, IR load, bypass/IDCODE/scan DR paths, async reset.
// Expected TDO streams are queued as stimulus is built and compared against the sampled TDO stream.
module tb_jtag_tap_ctrl;
  localparam int IR_W = 4;
  localparam logic [3:0]  OP_EXTEST  = 4'b0000;
  localparam logic [3:0]  OP_SAMPLE  = 4'b0001;
  localparam logic [3:0]  OP_IDCODE  = 4'b0010;
  localparam logic [3:0]  OP_SCAN    = 4'b0011;
  localparam logic [3:0]  OP_BYPASS  = 4'b1111;
  localparam logic [3:0]  OP_UNDEF   = 4'b0110;
  localparam logic [31:0] IDCODE_VAL = 32'h1234_5001;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0]  RESET_OP   = OP_IDCODE;
`else
  localparam logic [3:0]  RESET_OP   = OP_BYPASS;
`endif

  localparam logic [3:0] S_EX2_DR = 4'h0, S_EX1_DR = 4'h1, S_SH_DR  = 4'h2, S_PA_DR  = 4'h3;
  localparam logic [3:0] S_SEL_IR = 4'h4, S_UPD_DR = 4'h5, S_CAP_DR = 4'h6, S_SEL_DR = 4'h7;
  localparam logic [3:0] S_EX2_IR = 4'h8, S_EX1_IR = 4'h9, S_SH_IR  = 4'hA, S_PA_IR  = 4'hB;
  localparam logic [3:0] S_RTI    = 4'hC, S_UPD_IR = 4'hD, S_CAP_IR = 4'hE, S_TLR    = 4'hF;

  logic clock = 1'b0;
  logic rst_l = 1'b1;

  jtag_tap_ctrl_if #(.IR_W(IR_W)) jtag ();

  jtag_tap_ctrl #(.IR_W(IR_W)) dut (
    .clock (clock),
    .rst_l (rst_l),
    .jtag  (jtag)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];
  logic obs_q[$];
  int   cap_cnt, upd_cnt;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    case (s)
      S_TLR:    return t ? S_TLR    : S_RTI;
      S_RTI:    return t ? S_SEL_DR : S_RTI;
      S_SEL_DR: return t ? S_SEL_IR : S_CAP_DR;
      S_SEL_IR: return t ? S_TLR    : S_CAP_IR;
      S_CAP_DR: return t ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  return t ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: return t ? S_UPD_DR : S_PA_DR;
      S_PA_DR:  return t ? S_EX2_DR : S_PA_DR;
      S_EX2_DR: return t ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: return t ? S_SEL_DR : S_RTI;
      S_CAP_IR: return t ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  return t ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: return t ? S_UPD_IR : S_PA_IR;
      S_PA_IR:  return t ? S_EX2_IR : S_PA_IR;
      S_EX2_IR: return t ? S_UPD_IR : S_SH_IR;
      default:  return t ? S_SEL_DR : S_RTI;
    endcase
  endfunction

  // Shortest TMS walk from TLR to each state, bit i applied on clock i.
  task automatic path_to(input logic [3:0] s, output int len, output logic [7:0] bits);
    case (s)
      S_TLR:    begin len = 0; bits = 8'b0;        end
      S_RTI:    begin len = 1; bits = 8'b0;        end
      S_SEL_DR: begin len = 2; bits = 8'b10;       end
      S_CAP_DR: begin len = 3; bits = 8'b010;      end
      S_SH_DR:  begin len = 4; bits = 8'b0010;     end
      S_EX1_DR: begin len = 4; bits = 8'b1010;     end
      S_PA_DR:  begin len = 5; bits = 8'b01010;    end
      S_EX2_DR: begin len = 6; bits = 8'b101010;   end
      S_UPD_DR: begin len = 5; bits = 8'b11010;    end
      S_SEL_IR: begin len = 3; bits = 8'b110;      end
      S_CAP_IR: begin len = 4; bits = 8'b0110;     end
      S_SH_IR:  begin len = 5; bits = 8'b00110;    end
      S_EX1_IR: begin len = 5; bits = 8'b10110;    end
      S_PA_IR:  begin len = 6; bits = 8'b010110;   end
      S_EX2_IR: begin len = 7; bits = 8'b1010110;  end
      default:  begin len = 6; bits = 8'b110110;   end
    endcase
  endtask

  logic [3:0] mdl;

  task automatic tick(input logic t_ms, input logic t_di);
    jtag.tms = t_ms;
    jtag.tdi = t_di;
    @(posedge clock);
    #1;
    mdl = tap_next(mdl, t_ms);
    if (jtag.capture_dr) cap_cnt++;
    if (jtag.update_dr)  upd_cnt++;
  endtask

  task automatic goto_rti();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] op);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) tick(i == IR_W - 1, op[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // RTI -> one full DR scan of n bits -> RTI, recording tdo in each SH_DR cycle.
  task automatic shift_dr(input int n, input logic [63:0] bits);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      obs_q.push_back(jtag.tdo);
      tick(i == n - 1, bits[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [3:0] st;
    #1 rst_l = 1'b0;
    #1;
    st = dut.state;
    n_checks++;
    if (st !== S_TLR) begin n_errors++; $display("FAIL por_state got %h expected %h", st, S_TLR); end
    n_checks++;
    if (jtag.ir_out !== RESET_OP) begin n_errors++; $display("FAIL por_ir got %b expected %b", jtag.ir_out, RESET_OP); end
    n_checks++;
    if ({jtag.tdo, jtag.tdo_en, jtag.capture_dr, jtag.shift_dr, jtag.update_dr} !== 5'b0) begin
      n_errors++; $display("FAIL por_outputs got %b expected 00000",
        {jtag.tdo, jtag.tdo_en, jtag.capture_dr, jtag.shift_dr, jtag.update_dr});
    end
    @(posedge clock);
    #1 rst_l = 1'b1;
    mdl = S_TLR;

    goto_rti();
    load_ir(OP_SCAN);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if ({jtag.shift_dr, jtag.tdo_en} !== 2'b11) begin
      n_errors++; $display("FAIL pre_reset_shift got %b expected 11", {jtag.shift_dr, jtag.tdo_en});
    end
    rst_l = 1'b0;
    #2;
    st = dut.state;
    n_checks++;
    if (st !== S_TLR) begin n_errors++; $display("FAIL midshift_state got %h expected %h", st, S_TLR); end
    n_checks++;
    if (jtag.ir_out !== RESET_OP) begin n_errors++; $display("FAIL midshift_ir got %b expected %b", jtag.ir_out, RESET_OP); end
    n_checks++;
    if ({jtag.tdo, jtag.tdo_en, jtag.capture_dr, jtag.shift_dr, jtag.update_dr, jtag.scan_sel} !== 6'b0) begin
      n_errors++; $display("FAIL midshift_outputs got %b expected 000000",
        {jtag.tdo, jtag.tdo_en, jtag.capture_dr, jtag.shift_dr, jtag.update_dr, jtag.scan_sel});
    end
    rst_l = 1'b1;
    mdl = S_TLR;
  endtask

  task automatic test_fsm();
    logic [3:0] st;
    int         len;
    logic [7:0] bits;
    // Park a non-reset instruction so TLR entry has something to reload.
    goto_rti();
    load_ir(OP_SAMPLE);
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      path_to(s[3:0], len, bits);
      for (int i = 0; i < len; i++) tick(bits[i], 1'b0);
      st = dut.state;
      n_checks++;
      if (st !== s[3:0] || mdl !== s[3:0]) begin
        n_errors++; $display("FAIL fsm_reach got %h model %h expected %h", st, mdl, s[3:0]);
      end
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      st = dut.state;
      n_checks++;
      if (st !== S_TLR || jtag.tdo_en !== 1'b0 || jtag.ir_out !== RESET_OP) begin
        n_errors++; $display("FAIL fsm_tms5_from_%h got state %h tdo_en %b ir %b expected %h 0 %b",
          s[3:0], st, jtag.tdo_en, jtag.ir_out, S_TLR, RESET_OP);
      end
      tick(1'b0, 1'b0);
      st = dut.state;
      n_checks++;
      if (st !== S_RTI) begin n_errors++; $display("FAIL fsm_rti_from_%h got %h expected %h", s[3:0], st, S_RTI); end
    end
  endtask

  task automatic test_ir_extest();
    logic o, e, v;
    exp_q.delete(); obs_q.delete();
    goto_rti();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    for (int i = 0; i < IR_W; i++) begin
      obs_q.push_back(jtag.tdo);
      if (i == 2) begin
        n_checks++;
        if (jtag.ir_out !== RESET_OP) begin n_errors++; $display("FAIL ir_midshift got %b expected %b", jtag.ir_out, RESET_OP); end
      end
      tick(i == IR_W - 1, OP_EXTEST[i]);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (jtag.ir_out !== RESET_OP) begin n_errors++; $display("FAIL ir_in_upd got %b expected %b", jtag.ir_out, RESET_OP); end
    tick(1'b0, 1'b0);
    n_checks++;
    if (jtag.ir_out !== OP_EXTEST || {jtag.bsr_en, jtag.bsr_sel, jtag.scan_sel} !== 3'b110) begin
      n_errors++; $display("FAIL extest_modes got ir %b en/sel/scan %b expected %b 110",
        jtag.ir_out, {jtag.bsr_en, jtag.bsr_sel, jtag.scan_sel}, OP_EXTEST);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL ir_capture_tdo got %b expected %b", o, e); end
    end

    // bsr chain is now selected: tdo must follow bsr_so and all three strobes fire once.
    cap_cnt = 0; upd_cnt = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      v = 1'($urandom_range(0, 1));
      jtag.bsr_so = v;
      exp_q.push_back(v);
      #1 obs_q.push_back(jtag.tdo);
      n_checks++;
      if (jtag.shift_dr !== 1'b1) begin n_errors++; $display("FAIL bsr_shift_dr got %b expected 1", jtag.shift_dr); end
      tick(i == 3, 1'b0);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL bsr_tdo got %b expected %b", o, e); end
    end
    n_checks++;
    if (cap_cnt != 1 || upd_cnt != 1) begin
      n_errors++; $display("FAIL bsr_strobes got cap %0d upd %0d expected 1 1", cap_cnt, upd_cnt);
    end
  endtask

  task automatic test_idcode();
    logic        o, e;
    logic [31:0] idv;
    logic [63:0] tdi_bits;
    exp_q.delete(); obs_q.delete();
`ifdef JTAG_IDCODE_EN
    goto_rti();
    n_checks++;
    if (jtag.ir_out !== OP_IDCODE || {jtag.bsr_sel, jtag.scan_sel} !== 2'b00) begin
      n_errors++; $display("FAIL idcode_default_ir got %b sel %b expected %b 00",
        jtag.ir_out, {jtag.bsr_sel, jtag.scan_sel}, OP_IDCODE);
    end
    idv = IDCODE_VAL;
    for (int i = 0; i < 32; i++) exp_q.push_back(idv[i]);
    tdi_bits = {$urandom, $urandom};
    shift_dr(32, tdi_bits);
`else
    // Without the IDCODE register, OP_IDCODE falls through to bypass.
    idv = 32'h0;
    goto_rti();
    load_ir(OP_IDCODE);
    n_checks++;
    if (jtag.ir_out !== OP_IDCODE || {jtag.bsr_sel, jtag.scan_sel} !== 2'b00) begin
      n_errors++; $display("FAIL idcode_ir got %b sel %b expected %b 00",
        jtag.ir_out, {jtag.bsr_sel, jtag.scan_sel}, OP_IDCODE);
    end
    tdi_bits = 64'b1001;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    shift_dr(4, tdi_bits);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL idcode_tdo got %b expected %b (id %h)", o, e, idv); end
    end
  endtask

  task automatic test_bypass();
    logic        o, e;
    logic [63:0] tdi_bits;
    exp_q.delete(); obs_q.delete();
    goto_rti();
    load_ir(OP_BYPASS);
    cap_cnt = 0; upd_cnt = 0;
    tdi_bits = 64'b1011;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    shift_dr(4, tdi_bits);
    n_checks++;
    if (cap_cnt != 0 || upd_cnt != 0) begin
      n_errors++; $display("FAIL bypass_strobes got cap %0d upd %0d expected 0 0", cap_cnt, upd_cnt);
    end

    // Undefined opcode behaves as bypass: 1-cycle delayed echo after a captured 0.
    load_ir(OP_UNDEF);
    tdi_bits = {32'h0, $urandom};
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(tdi_bits[i]);
    shift_dr(8, tdi_bits);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL bypass_tdo got %b expected %b", o, e); end
    end
  endtask

  task automatic test_scan_pause();
    logic o, e, v;
    exp_q.delete(); obs_q.delete();
    goto_rti();
    load_ir(OP_SCAN);
    n_checks++;
    if ({jtag.scan_sel, jtag.bsr_sel, jtag.bsr_en} !== 3'b100) begin
      n_errors++; $display("FAIL scan_modes got %b expected 100", {jtag.scan_sel, jtag.bsr_sel, jtag.bsr_en});
    end
    cap_cnt = 0; upd_cnt = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int seg = 0; seg < 2; seg++) begin
      for (int i = 0; i < 3; i++) begin
        v = 1'($urandom_range(0, 1));
        jtag.scan_so = v;
        exp_q.push_back(v);
        #1 obs_q.push_back(jtag.tdo);
        n_checks++;
        if ({jtag.shift_dr, jtag.tdo_en} !== 2'b11) begin
          n_errors++; $display("FAIL scan_shift seg %0d got %b expected 11", seg, {jtag.shift_dr, jtag.tdo_en});
        end
        tick(i == 2, 1'b1);
      end
      if (seg == 0) begin
        jtag.scan_so = 1'b1;
        for (int p = 0; p < 3; p++) begin
          tick(1'b0, 1'b1);
          n_checks++;
          if ({jtag.shift_dr, jtag.tdo_en, jtag.tdo} !== 3'b000) begin
            n_errors++; $display("FAIL scan_pause %0d got %b expected 000", p, {jtag.shift_dr, jtag.tdo_en, jtag.tdo});
          end
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
      end
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (cap_cnt != 1 || upd_cnt != 1) begin
      n_errors++; $display("FAIL scan_strobes got cap %0d upd %0d expected 1 1", cap_cnt, upd_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL scan_tdo got %b expected %b", o, e); end
    end
  endtask

  initial begin
    jtag.tms     = 1'b1;
    jtag.tdi     = 1'b0;
    jtag.bsr_so  = 1'b0;
    jtag.scan_so = 1'b0;
    mdl          = S_TLR;
    cap_cnt      = 0;
    upd_cnt      = 0;
    test_reset();
    test_fsm();
    test_ir_extest();
    test_idcode();
    test_bypass();
    test_scan_pause();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
